// File: rtl/div_pkg.sv
// Shared constants and state encoding for the Execute-stage DIV/MOD sequencer.
package div_pkg;

    localparam int WIDTH = 19;
    localparam int CNT_W = 5;

    localparam logic [2:0] ALU_SUM  = 3'b000;
    localparam logic [2:0] ALU_RES  = 3'b001;
    localparam logic [2:0] ALU_MULT = 3'b010;
    localparam logic [2:0] ALU_DIV  = 3'b011;
    localparam logic [2:0] ALU_MOD  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 19
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             nextBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] newRem,
    output logic             qBit
);

    logic [WIDTH:0] partialS;
    logic [WIDTH:0] diffS;

    // The partial remainder keeps its top bit so divisors with the MSB set still work.
    always_comb begin
        partialS = {rem, nextBit};
        diffS    = partialS - {1'b0, divisor};
        qBit     = (partialS >= {1'b0, divisor});
        if (qBit) begin
            newRem = diffS[WIDTH-1:0];
        end else begin
            newRem = partialS[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_mod_sequencer.sv
// Iterative unsigned DIV/MOD controller that stalls Execute while a division runs.
// Optional macro FAST_PATH_EN: divisor==1 or dividend<divisor finish after one stall cycle.
module div_mod_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH,
    parameter int CNT_W = div_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_mod,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    div_state_t       stateR;
    logic [CNT_W-1:0] cntR;
    logic [WIDTH-1:0] remR;
    logic [WIDTH-1:0] quotR;
    logic [WIDTH-1:0] divR;
    logic             opModR;
    logic             doneR;
    logic             dbzR;
    logic [WIDTH-1:0] resultR;

    logic [WIDTH-1:0] stepRemS;
    logic             stepQS;
    logic [WIDTH-1:0] nextQuotS;
    logic             fastS;
    logic [WIDTH-1:0] fastResS;

    // quotR starts as the dividend and shifts quotient bits in from the bottom.
    div_step #(.WIDTH(WIDTH)) uStep (
        .rem     (remR),
        .nextBit (quotR[WIDTH-1]),
        .divisor (divR),
        .newRem  (stepRemS),
        .qBit    (stepQS)
    );

    assign nextQuotS = {quotR[WIDTH-2:0], stepQS};

`ifdef FAST_PATH_EN
    // Trivial operand pairs whose answer is known without iterating.
    always_comb begin
        fastS    = 1'b0;
        fastResS = {WIDTH{1'b0}};
        if (divisor == {{(WIDTH-1){1'b0}}, 1'b1}) begin
            fastS    = 1'b1;
            fastResS = op_mod ? {WIDTH{1'b0}} : dividend;
        end else if ((divisor != {WIDTH{1'b0}}) && (dividend < divisor)) begin
            fastS    = 1'b1;
            fastResS = op_mod ? dividend : {WIDTH{1'b0}};
        end else begin
            fastS    = 1'b0;
            fastResS = {WIDTH{1'b0}};
        end
    end
`else
    // Fast path compiled out: every operation iterates.
    always_comb begin
        fastS    = 1'b0;
        fastResS = {WIDTH{1'b0}};
    end
`endif

    // Hold the pipeline while an operation is requested or running; never during flush or DONE.
    assign stall = !reset && !flush && (((stateR == IDLE) && start) || (stateR == BUSY));

    assign done        = doneR;
    assign div_by_zero = dbzR;
    assign result      = resultR;

    // Sequencer state, iteration datapath and registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR  <= IDLE;
            cntR    <= {CNT_W{1'b0}};
            remR    <= {WIDTH{1'b0}};
            quotR   <= {WIDTH{1'b0}};
            divR    <= {WIDTH{1'b0}};
            opModR  <= 1'b0;
            doneR   <= 1'b0;
            dbzR    <= 1'b0;
            resultR <= {WIDTH{1'b0}};
        end else if (flush) begin
            stateR <= IDLE;
            doneR  <= 1'b0;
            dbzR   <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    doneR <= 1'b0;
                    dbzR  <= 1'b0;
                    if (start && fastS) begin
                        resultR <= fastResS;
                        doneR   <= 1'b1;
                        stateR  <= DONE;
                    end else if (start) begin
                        quotR  <= dividend;
                        divR   <= divisor;
                        opModR <= op_mod;
                        remR   <= {WIDTH{1'b0}};
                        cntR   <= CNT_W'(WIDTH);
                        stateR <= BUSY;
                    end else begin
                        stateR <= IDLE;
                    end
                end
                BUSY: begin
                    remR  <= stepRemS;
                    quotR <= nextQuotS;
                    cntR  <= cntR - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cntR == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        // A zero divisor falls out naturally: all-ones quotient, remainder = dividend.
                        resultR <= opModR ? stepRemS : nextQuotS;
                        doneR   <= 1'b1;
                        dbzR    <= (divR == {WIDTH{1'b0}});
                        stateR  <= DONE;
                    end else begin
                        stateR <= BUSY;
                    end
                end
                DONE: begin
                    doneR  <= 1'b0;
                    dbzR   <= 1'b0;
                    stateR <= IDLE;
                end
                default: begin
                    doneR  <= 1'b0;
                    dbzR   <= 1'b0;
                    stateR <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_mod_sequencer.sv
// Self-checking bench for div_mod_sequencer against an arithmetic reference model.
module tb_div_mod_sequencer;

    localparam int W = 19;
    localparam logic [W-1:0] ALL_ONES = 19'h7FFFF;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_mod;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         flush;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    int asserts = 0;
    int fails   = 0;

    int           stalls, lat;
    logic         got, dbz;
    logic [W-1:0] res;

    div_mod_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op_mod      (op_mod),
        .dividend    (dividend),
        .divisor     (divisor),
        .flush       (flush),
        .stall       (stall),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        if (b == 19'd0) return m ? a : ALL_ONES;
        return m ? (a % b) : (a / b);
    endfunction

    function automatic int refLatency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef FAST_PATH_EN
        if (b == 19'd1 || (b != 19'd0 && a < b)) return 1;
`endif
        return W + 1;
    endfunction

    // Drive one operation from a negedge; report stall count and the cycle index of done.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output int nStall, output int nLat, output logic gotDone,
                         output logic [W-1:0] r, output logic z);
        start = 1'b1; op_mod = m; dividend = a; divisor = b;
        nStall = 0; nLat = 0; gotDone = 1'b0; r = 19'd0; z = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (stall) nStall++;
            if (done) begin
                gotDone = 1'b1; nLat = c; r = result; z = div_by_zero;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        logic [W-1:0] expR;
        int expL;
        expR = refResult(a, b, m);
        expL = refLatency(a, b);
        runOp(a, b, m, stalls, lat, got, res, dbz);
        asserts++;
        if (!got) begin
            fails++; $display("FAIL %s timeout: no done within 64 cycles", name);
        end else begin
            if (res !== expR || dbz !== (b == 19'd0) || lat != expL || stalls != expL) begin
                fails++;
                $display("FAIL %s a=%0h b=%0h mod=%0d: got res=%0h dbz=%0d lat=%0d stalls=%0d, want res=%0h dbz=%0d lat=%0d",
                         name, a, b, m, res, dbz, lat, stalls, expR, (b == 19'd0), expL);
            end
        end
    endtask

    task automatic test_reset();
        asserts++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 19'd0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset: stall=%0d done=%0d result=%0h dbz=%0d, want all 0", stall, done, result, div_by_zero);
        end
    endtask

    task automatic test_div_basic();
        checkOp("div_20_10", 19'd20, 19'd10, 1'b0);
        @(negedge clk); start = 1'b0; #1;
        asserts++;
        if (done !== 1'b0 || stall !== 1'b0) begin
            fails++; $display("FAIL done_pulse: done=%0d stall=%0d after pulse, want 0 0", done, stall);
        end
        checkOp("div_3_1", 19'd3, 19'd1, 1'b0);
        @(negedge clk);
        checkOp("mod_2_9", 19'd2, 19'd9, 1'b1);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_back_to_back();
        checkOp("b2b_mod_29_5", 19'd29, 19'd5, 1'b1);
        @(negedge clk);
        checkOp("b2b_mod_7ffff_3", ALL_ONES, 19'd3, 1'b1);
        @(negedge clk);
        checkOp("b2b_div_7ffff_40000", ALL_ONES, 19'h40000, 1'b0);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_div_zero();
        checkOp("div_7_0", 19'd7, 19'd0, 1'b0);
        @(negedge clk);
        checkOp("mod_7_0", 19'd7, 19'd0, 1'b1);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_flush();
        logic [W-1:0] prev;
        logic sawDone;
        prev = refResult(19'd7, 19'd0, 1'b1);
        start = 1'b1; op_mod = 1'b0; dividend = 19'd100; divisor = 19'd7;
        for (int i = 0; i < 5; i++) @(negedge clk);
        flush = 1'b1; start = 1'b0; #1;
        asserts++;
        if (stall !== 1'b0) begin
            fails++; $display("FAIL flush_stall: stall=%0d, want 0", stall);
        end
        @(negedge clk); flush = 1'b0; #1;
        asserts++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== prev) begin
            fails++; $display("FAIL flush_after: stall=%0d done=%0d result=%0h, want 0 0 %0h", stall, done, result, prev);
        end
        sawDone = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            if (done) sawDone = 1'b1;
        end
        asserts++;
        if (sawDone) begin
            fails++; $display("FAIL flush_no_done: done seen after flush, want none");
        end
        @(negedge clk);
        checkOp("div_100_7_after_flush", 19'd100, 19'd7, 1'b0);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_async_reset();
        start = 1'b1; op_mod = 1'b1; dividend = 19'd1000; divisor = 19'd13;
        for (int i = 0; i < 8; i++) @(negedge clk);
        #2; reset = 1'b1; start = 1'b0; #1;
        asserts++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 19'd0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: stall=%0d done=%0d result=%0h dbz=%0d, want all 0", stall, done, result, div_by_zero);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checkOp("mod_29_5_after_reset", 19'd29, 19'd5, 1'b1);
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic m;
        for (int i = 0; i < 24; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 5))
                0: b = 19'd0;
                1: b = 19'd1;
                2: b = W'($urandom_range(2, 15));
                3: b = a + W'($urandom_range(1, 100));
                default: b = W'($urandom);
            endcase
            m = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOp("random", a, b, m);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk); start = 1'b0;
            end
        end
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op_mod = 1'b0; dividend = 19'd0; divisor = 19'd0; flush = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_div_basic();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_div_zero();
        @(negedge clk);
        test_flush();
        @(negedge clk);
        test_async_reset();
        @(negedge clk);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
